// File: rtl/cocc_seq_pkg.sv
// Shared definitions for the COCC CPU sequencer.
// Contents:
//   seq_state_e   - state encodings (STATE_*), also driven out on the debug state port
//   OPC_*         - opcode values decoded in DECODE
//   JMP_*         - jump condition codes carried in the IR operand2 field
//   CTRL_*        - bit positions inside the 16-line control word
//   is_mem_state  - which states wait on mem_ready
package cocc_seq_pkg;

   localparam int unsigned SEQ_STATE_W = 5;
   localparam int unsigned CTRL_W      = 16;

   typedef enum logic [SEQ_STATE_W-1:0] {
      STATE_FETCH_PC   = 5'd0,
      STATE_FETCH_INST = 5'd1,
      STATE_DECODE     = 5'd2,
      STATE_ALU_EXEC   = 5'd3,
      STATE_ALU_OUT    = 5'd4,
      STATE_MOV_REG    = 5'd5,
      STATE_SET_MAR    = 5'd6,
      STATE_SET_REG    = 5'd7,
      STATE_LOAD_ADDR  = 5'd8,
      STATE_SET_MEM    = 5'd9,
      STATE_FETCH_SP   = 5'd10,
      STATE_STACK_REG  = 5'd11,
      STATE_STORE_PC   = 5'd12,
      STATE_TMP_JUMP   = 5'd13,
      STATE_INC_SP     = 5'd14,
      STATE_RET        = 5'd15,
      STATE_JUMP       = 5'd16,
      STATE_HALT       = 5'd17
   } seq_state_e;

   // Opcode values
   localparam int unsigned OPC_NOP  = 0;
   localparam int unsigned OPC_ALU  = 1;
   localparam int unsigned OPC_MOV  = 2;
   localparam int unsigned OPC_LDI  = 3;
   localparam int unsigned OPC_LD   = 4;
   localparam int unsigned OPC_ST   = 5;
   localparam int unsigned OPC_PUSH = 6;
   localparam int unsigned OPC_CALL = 7;
   localparam int unsigned OPC_RET  = 8;
   localparam int unsigned OPC_JMP  = 9;
   localparam int unsigned OPC_HLT  = 10;

   // Jump condition codes
   localparam int unsigned JMP_ALWAYS = 0;
   localparam int unsigned JMP_JZ     = 1;
   localparam int unsigned JMP_JNZ    = 2;
   localparam int unsigned JMP_JC     = 3;
   localparam int unsigned JMP_JNC    = 4;

   // Control word bit positions
   localparam int unsigned CTRL_DA   = 0;
   localparam int unsigned CTRL_II   = 1;
   localparam int unsigned CTRL_CI   = 2;
   localparam int unsigned CTRL_CO   = 3;
   localparam int unsigned CTRL_CS   = 4;
   localparam int unsigned CTRL_RFI  = 5;
   localparam int unsigned CTRL_RFO  = 6;
   localparam int unsigned CTRL_EO   = 7;
   localparam int unsigned CTRL_EE   = 8;
   localparam int unsigned CTRL_MI   = 9;
   localparam int unsigned CTRL_RO   = 10;
   localparam int unsigned CTRL_RI   = 11;
   localparam int unsigned CTRL_SO   = 12;
   localparam int unsigned CTRL_SD   = 13;
   localparam int unsigned CTRL_SI   = 14;
   localparam int unsigned CTRL_HALT = 15;

   // States that hold until the RAM signals completion. JUMP only touches
   // memory when the jump is taken; a not-taken JUMP is a single idle cycle.
   function automatic logic is_mem_state(input seq_state_e s, input logic taken);
      logic mem;
      case (s)
         STATE_FETCH_INST, STATE_LOAD_ADDR, STATE_SET_REG, STATE_RET,
         STATE_STORE_PC, STATE_SET_MEM, STATE_STACK_REG: mem = 1'b1;
         STATE_JUMP: mem = taken;
         default:    mem = 1'b0;
      endcase
      return mem;
   endfunction

endpackage

// File: rtl/seq_cond_eval.sv
// Jump condition evaluator for the COCC sequencer.
// Purely combinational so it can be shared with future branch prediction.
// Ports:
//   cond        - condition code from IR operand2
//   flag_zero   - ALU zero flag
//   flag_carry  - ALU carry flag
//   taken       - 1 when the condition holds; unknown codes are never taken
module seq_cond_eval
   import cocc_seq_pkg::*;
#(
   parameter int unsigned COND_W = 3
) (
   input  logic [COND_W-1:0] cond,
   input  logic              flag_zero,
   input  logic              flag_carry,
   output logic              taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_W'(JMP_ALWAYS): taken = 1'b1;
         COND_W'(JMP_JZ):     taken = flag_zero;
         COND_W'(JMP_JNZ):    taken = ~flag_zero;
         COND_W'(JMP_JC):     taken = flag_carry;
         COND_W'(JMP_JNC):    taken = ~flag_carry;
         default:             taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 8-bit COCC CPU.
// Steps fetch/decode/execute itself and emits the 16-line control word.
// Optional build macro: COCC_SEQ_TIMEOUT_EN - adds a memory wait-state
// timeout that halts the sequencer and raises a sticky fault.
// Ports:
//   clk, rst    - clock (rising edge) and asynchronous active-high reset
//   run         - advance enable; state and outputs hold when low
//   opcode      - IR opcode field, valid from DECODE onward
//   cond        - IR operand2 field, jump condition code
//   flag_zero   - ALU zero flag, sampled in DECODE
//   flag_carry  - ALU carry flag, sampled in DECODE
//   mem_ready   - RAM access completes this cycle
//   ctrl        - control word (da,ii,ci,co,cs,rfi,rfo,eo,ee,mi,ro,ri,so,sd,si,halt)
//   state       - current state encoding for trace
//   jump_taken  - registered condition result for the current instruction
//   fault       - memory timeout fault (tied low without the macro)
module cpu_sequencer
   import cocc_seq_pkg::*;
#(
   parameter int unsigned OP_W        = 5,
   parameter int unsigned COND_W      = 3,
   parameter int unsigned STATE_W     = 5,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [OP_W-1:0]    opcode,
   input  logic [COND_W-1:0]  cond,
   input  logic               flag_zero,
   input  logic               flag_carry,
   input  logic               mem_ready,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [STATE_W-1:0] state,
   output logic               jump_taken,
   output logic               fault
);

   seq_state_e        state_q;
   seq_state_e        next_state;
   seq_state_e        decode_target;
   logic              jump_taken_q;
   logic              cond_taken;
   logic              mem_wait;
   logic [CTRL_W-1:0] ctrl_dec;

   seq_cond_eval #(
      .COND_W(COND_W)
   ) u_cond_eval (
      .cond      (cond),
      .flag_zero (flag_zero),
      .flag_carry(flag_carry),
      .taken     (cond_taken)
   );

   assign mem_wait = is_mem_state(state_q, jump_taken_q) & ~mem_ready;

   // Instruction body entry point chosen in DECODE
   always_comb begin
      decode_target = STATE_FETCH_PC;
      case (opcode)
         OP_W'(OPC_ALU):  decode_target = STATE_ALU_EXEC;
         OP_W'(OPC_MOV):  decode_target = STATE_MOV_REG;
         OP_W'(OPC_LDI):  decode_target = STATE_SET_MAR;
         OP_W'(OPC_LD):   decode_target = STATE_LOAD_ADDR;
         OP_W'(OPC_ST):   decode_target = STATE_LOAD_ADDR;
         OP_W'(OPC_PUSH): decode_target = STATE_FETCH_SP;
         OP_W'(OPC_CALL): decode_target = STATE_FETCH_SP;
         OP_W'(OPC_RET):  decode_target = STATE_INC_SP;
         OP_W'(OPC_JMP):  decode_target = STATE_JUMP;
         OP_W'(OPC_HLT):  decode_target = STATE_HALT;
         default:         decode_target = STATE_FETCH_PC;
      endcase
   end

   // Successor assuming the current state is allowed to advance. Shared
   // states (LOAD_ADDR, FETCH_SP) branch on the still-held IR opcode.
   always_comb begin
      next_state = STATE_FETCH_PC;
      case (state_q)
         STATE_FETCH_PC:   next_state = STATE_FETCH_INST;
         STATE_FETCH_INST: next_state = STATE_DECODE;
         STATE_DECODE:     next_state = decode_target;
         STATE_ALU_EXEC:   next_state = STATE_ALU_OUT;
         STATE_SET_MAR:    next_state = STATE_SET_REG;
         STATE_LOAD_ADDR:  next_state = (opcode == OP_W'(OPC_ST)) ? STATE_SET_MEM
                                                                   : STATE_SET_REG;
         STATE_FETCH_SP: begin
            if (opcode == OP_W'(OPC_PUSH))      next_state = STATE_STACK_REG;
            else if (opcode == OP_W'(OPC_CALL)) next_state = STATE_STORE_PC;
            else if (opcode == OP_W'(OPC_RET))  next_state = STATE_RET;
            else                                next_state = STATE_FETCH_PC;
         end
         STATE_STORE_PC:   next_state = STATE_TMP_JUMP;
         STATE_INC_SP:     next_state = STATE_FETCH_SP;
         STATE_HALT:       next_state = STATE_HALT;
         default:          next_state = STATE_FETCH_PC;
      endcase
   end

`ifdef COCC_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt_q;
   logic             fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STATE_FETCH_PC;
         jump_taken_q <= 1'b0;
         wait_cnt_q   <= '0;
         fault_q      <= 1'b0;
      end else if (run && state_q != STATE_HALT) begin
         if (mem_wait) begin
            // This wait cycle is the MEM_TIMEOUT-th one in the current state
            if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               state_q    <= STATE_HALT;
               fault_q    <= 1'b1;
               wait_cnt_q <= '0;
            end else begin
               wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
         end else begin
            state_q    <= next_state;
            wait_cnt_q <= '0;
            if (state_q == STATE_DECODE) jump_taken_q <= cond_taken;
         end
      end
   end

   assign fault = fault_q;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STATE_FETCH_PC;
         jump_taken_q <= 1'b0;
      end else if (run && state_q != STATE_HALT && !mem_wait) begin
         state_q <= next_state;
         if (state_q == STATE_DECODE) jump_taken_q <= cond_taken;
      end
   end

   logic unused_timeout;
   assign unused_timeout = (MEM_TIMEOUT == 0);
   assign fault          = 1'b0;
`endif

   // Control word decode
   always_comb begin
      ctrl_dec = '0;
      case (state_q)
         STATE_FETCH_PC: begin
            ctrl_dec[CTRL_CO] = 1'b1;
            ctrl_dec[CTRL_MI] = 1'b1;
            ctrl_dec[CTRL_CI] = 1'b1;
         end
         STATE_FETCH_INST: begin
            ctrl_dec[CTRL_RO] = 1'b1;
            ctrl_dec[CTRL_II] = 1'b1;
         end
         STATE_ALU_EXEC: ctrl_dec[CTRL_EE] = 1'b1;
         STATE_ALU_OUT: begin
            ctrl_dec[CTRL_EO]  = 1'b1;
            ctrl_dec[CTRL_RFI] = 1'b1;
         end
         STATE_MOV_REG: begin
            ctrl_dec[CTRL_RFO] = 1'b1;
            ctrl_dec[CTRL_RFI] = 1'b1;
         end
         STATE_SET_MAR: ctrl_dec[CTRL_DA] = 1'b1;
         STATE_SET_REG: begin
            ctrl_dec[CTRL_RO]  = 1'b1;
            ctrl_dec[CTRL_RFI] = 1'b1;
         end
         STATE_LOAD_ADDR: begin
            ctrl_dec[CTRL_MI] = 1'b1;
            ctrl_dec[CTRL_RO] = 1'b1;
         end
         STATE_SET_MEM: begin
            ctrl_dec[CTRL_RFO] = 1'b1;
            ctrl_dec[CTRL_RI]  = 1'b1;
         end
         STATE_FETCH_SP: ctrl_dec[CTRL_SO] = 1'b1;
         STATE_STACK_REG: begin
            ctrl_dec[CTRL_RFO] = 1'b1;
            ctrl_dec[CTRL_RI]  = 1'b1;
            ctrl_dec[CTRL_SI]  = 1'b1;
            ctrl_dec[CTRL_SD]  = 1'b1;
         end
         STATE_STORE_PC: begin
            ctrl_dec[CTRL_CO] = 1'b1;
            ctrl_dec[CTRL_RI] = 1'b1;
         end
         STATE_TMP_JUMP: begin
            ctrl_dec[CTRL_RFO] = 1'b1;
            ctrl_dec[CTRL_CI]  = 1'b1;
            ctrl_dec[CTRL_CS]  = 1'b1;
            ctrl_dec[CTRL_SI]  = 1'b1;
            ctrl_dec[CTRL_SD]  = 1'b1;
         end
         STATE_INC_SP: ctrl_dec[CTRL_SI] = 1'b1;
         STATE_RET: begin
            ctrl_dec[CTRL_RO] = 1'b1;
            ctrl_dec[CTRL_CI] = 1'b1;
            ctrl_dec[CTRL_CS] = 1'b1;
         end
         STATE_JUMP: begin
            ctrl_dec[CTRL_RO] = jump_taken_q;
            ctrl_dec[CTRL_CI] = jump_taken_q;
            ctrl_dec[CTRL_CS] = jump_taken_q;
         end
         STATE_HALT: ctrl_dec[CTRL_HALT] = 1'b1;
         default:    ctrl_dec = '0;
      endcase
   end

   // No lines are driven while reset is held
   assign ctrl       = rst ? '0 : ctrl_dec;
   assign state      = STATE_W'(state_q);
   assign jump_taken = jump_taken_q;

endmodule
